// File: rtl/dma_cmd_queue_if.sv
// Descriptor-queue bus: host push side, copier launch/complete side and
// status/interrupt signals for dma_cmd_queue.
interface dma_cmd_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int SW    = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Host descriptor push
  logic          push;
  logic [AW-1:0] push_src;
  logic [AW-1:0] push_dst;
  logic [SW-1:0] push_size;

  // Queue status
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;

  // Copier command and completion
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [SW-1:0] copy_size;
  logic          start;
  logic          finished;

  // Dispatcher status and interrupt
  logic          busy;
  logic          done_pulse;
  logic [7:0]    done_count;
  logic          irq;
  logic          irq_clr;

  // Host/copier side that drives the queue
  modport master (
    output push, push_src, push_dst, push_size, finished, irq_clr,
    input  full, count, overflow, src_addr, dst_addr, copy_size, start,
           busy, done_pulse, done_count, irq
  );

  // The queue itself
  modport slave (
    input  push, push_src, push_dst, push_size, finished, irq_clr,
    output full, count, overflow, src_addr, dst_addr, copy_size, start,
           busy, done_pulse, done_count, irq
  );
endinterface

// File: rtl/dma_cmd_queue.sv
// Descriptor FIFO plus dispatcher for the copier DMA. Descriptors are launched
// one at a time; the head stays counted in the FIFO until it retires, so
// count includes the in-flight descriptor.
module dma_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int SW    = 8
) (
  input logic           CLK,
  input logic           nRST,
  dma_cmd_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RETIRE = 2'd3
  } state_t;

  state_t        state;

  logic [AW-1:0] src_mem  [DEPTH];
  logic [AW-1:0] dst_mem  [DEPTH];
  logic [SW-1:0] size_mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [SW-1:0] size_q;
  logic          start_q;
  logic          done_q;
  logic [7:0]    done_cnt_q;
  logic          ovf_q;
  logic          irq_q;

  logic          full_w;
  logic          push_ok;
  logic          pop;
  logic          drain;

  // full uses the registered (pre-edge) count, so a push is never accepted
  // into a slot that is only being freed on the same edge.
  assign full_w  = (cnt == CW'(DEPTH));
  assign push_ok = bus.push && !full_w;
  assign pop     = (state == RETIRE);
  // Queue drains on this edge: last entry retires and nothing replaces it.
  assign drain   = pop && (cnt == CW'(1)) && !push_ok;

  // Descriptor storage; contents are only meaningful where count says so.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      src_mem[wr_ptr]  <= bus.push_src;
      dst_mem[wr_ptr]  <= bus.push_dst;
      size_mem[wr_ptr] <= bus.push_size;
    end
  end

  // FIFO pointers and occupancy; push and pop may both happen on one edge.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      cnt <= cnt + CW'(push_ok) - CW'(pop);
    end
  end

  // Dispatcher FSM with registered copier command and retire outputs.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      size_q     <= '0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (cnt != '0) begin
            // Command outputs only ever change here and are held until the
            // next launch.
            src_q   <= src_mem[rd_ptr];
            dst_q   <= dst_mem[rd_ptr];
            size_q  <= size_mem[rd_ptr];
            // Zero-length descriptors are skipped without touching the copier.
            start_q <= (size_mem[rd_ptr] != '0);
            state   <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (size_q == '0) begin
            done_q <= 1'b1;
            state  <= RETIRE;
          end else begin
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (bus.finished) begin
            done_q <= 1'b1;
            state  <= RETIRE;
          end
        end
        RETIRE: begin
          done_cnt_q <= done_cnt_q + 8'd1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Sticky flags: overflow until reset, irq until cleared (set wins over clear).
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ovf_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (bus.push && full_w) begin
        ovf_q <= 1'b1;
      end
      if (drain) begin
        irq_q <= 1'b1;
      end else if (bus.irq_clr) begin
        irq_q <= 1'b0;
      end
    end
  end

  assign bus.full       = full_w;
  assign bus.count      = cnt;
  assign bus.overflow   = ovf_q;
  assign bus.src_addr   = src_q;
  assign bus.dst_addr   = dst_q;
  assign bus.copy_size  = size_q;
  assign bus.start      = start_q;
  assign bus.busy       = (state != IDLE);
  assign bus.done_pulse = done_q;
  assign bus.done_count = done_cnt_q;
  assign bus.irq        = irq_q;

endmodule
